gpio_mulcnt_seq: RTL and testbench
==================================

Name: gpio_mulcnt_seq

Overview:
- Bus-mapped GPIO-emulator peripheral with a parametrised, fully clk-synchronous datapath.
- Computes the product of two OP_W-bit operands with a bit-serial shift-add multiplier, then the bit-serial popcount of the result.
- Flags overflow beyond RES_W bits and counts completed operations on gpio_out.
- Replaces strobe-clocked register logic: srd/swr are sampled in the clk domain.

Parameters:
- OP_W, 24, operand width (2..32).
- RES_W, 32, result register width (<=32, >=OP_W).
- CNT_W, 16, operation-counter width (<=32).
- BASE_ADDR, 16'h0380, register-block base address.

Ports:
- clk  in  1  system clock, rising edge.
- n_reset  in  1  asynchronous, active-low reset.
- saddress  in  16  bus address.
- srd  in  1  read strobe; sampled on clk, rising edge detected.
- swr  in  1  write strobe; sampled on clk, rising edge detected.
- sdata_in  in  32  write data.
- sdata_out  out  32  registered read data.
- gpio_in  in  32  GPIO input.
- gpio_latch  in  1  captures gpio_in when high at a clk edge.
- gpio_out  out  32  {zero-extend, op_count}.
- gpio_in_s_insp  out  32  latched gpio_in.

Behaviour:
- Reset (async, n_reset low):
  - A1, A2, W, L, op_count, sdata_out, gpio_in_s = 0.
  - Status: valid=1, done=0, busy=0.
  - State = IDLE.
  - Reset mid-operation aborts the operation with no partial update.
- Strobe detection: srd_q/swr_q registered; event = strobe & ~strobe_q. A held strobe is exactly one event.
- Register map (offsets from BASE_ADDR):
  - 0x00 A1 (RW; low OP_W bits stored).
  - 0x08 A2 (RW).
  - 0x10 W (RO).
  - 0x18 L (RO).
  - 0x20 CTRL/STATUS: a write starts an operation, data ignored; read = {29'b0, busy, done, valid}.
- Writes:
  - Applied on the detection edge.
  - A1/A2 writes while busy are ignored.
  - Start while busy is ignored; the counter is unaffected.
  - Writes to RO or unmapped addresses are ignored.
- Reads:
  - sdata_out loads the addressed value (zero-extended) one clk after detection and holds until the next read event.
  - Unmapped address returns 0.
  - A read and a write in the same cycle are both processed; the read returns the pre-write value.
- FSM IDLE -> MULT -> COUNT -> DONE -> IDLE:
  - IDLE: waits for start. On start, load acc=0, mcand=A1 (2*OP_W wide), mplier=A2, bit index=0. Set busy=1, done=0.
  - MULT, OP_W cycles: if mplier[0], acc += mcand; then mcand <<= 1, mplier >>= 1.
  - COUNT, RES_W cycles: shift acc[RES_W-1:0] right one bit per cycle, adding its LSB to a ones counter of width clog2(RES_W+1).
  - DONE, 1 cycle:
    - W = acc[RES_W-1:0].
    - L = ones count.
    - valid = (acc[2*OP_W-1:RES_W] == 0); valid is forced to 1 when 2*OP_W <= RES_W.
    - done=1, busy=0; op_count += 1, wrapping 2^CNT_W-1 -> 0.
- Latency: W, L, status and op_count are visible exactly OP_W+RES_W+2 clk after start detection (default 58).
- W and L keep the last completed values until the next DONE. Reads during busy return the old values.
- gpio_in_s <= gpio_in on every clk with gpio_latch=1.
- gpio_in_s_insp = gpio_in_s; gpio_out = zero-extended op_count.

Test Plan:
- A1=3, A2=5, start:
  - busy=1 next cycle.
  - At +58: W=0x0000000F, L=4, status=0b010|valid -> 0x3, gpio_out=1.
- A1=0xFFFFFF, A2=0xFFFFFF, start -> W=0xFE000001, L=8, status=0x2 (valid=0).
- Start mid-operation, and A1 write mid-operation:
  - Both ignored.
  - The result reflects the original operands.
  - gpio_out increments only once.
- Reset asserted at cycle 10 of MULT:
  - All outputs 0, status=0x1.
  - After release, a fresh start with A1=2, A2=7 gives W=14, L=3.
- 0x10000 back-to-back starts (CNT_W=16) -> gpio_out wraps to 0. Read of unmapped 0x03A8 -> sdata_out=0.
- swr held high for 5 cycles at CTRL -> exactly one operation.
- gpio_latch pulse with gpio_in=0xA5A5A5A5 -> gpio_in_s_insp=0xA5A5A5A5, held after gpio_in changes.

Source files
------------

// File: rtl/gpio_mulcnt_seq.sv
// Purpose: bus-mapped GPIO emulator computing A1*A2 by shift-add, then the popcount of the product.
// Latency: W/L/status/op_count update OP_W+RES_W+1 clk after the start edge (strobe rise to visible: OP_W+RES_W+2).
// Backpressure: none; starts and A1/A2 writes arriving while busy are dropped, reads always complete.
module gpio_mulcnt_seq #(
   parameter int          OP_W      = 24,
   parameter int          RES_W     = 32,
   parameter int          CNT_W     = 16,
   parameter logic [15:0] BASE_ADDR = 16'h0380
) (
   input  logic        clk,
   input  logic        n_reset,
   input  logic [15:0] saddress,
   input  logic        srd,
   input  logic        swr,
   input  logic [31:0] sdata_in,
   output logic [31:0] sdata_out,
   input  logic [31:0] gpio_in,
   input  logic        gpio_latch,
   output logic [31:0] gpio_out,
   output logic [31:0] gpio_in_s_insp
);

   // The accumulator must hold the full product and also be wide enough to slice RES_W bits.
   localparam int PW     = 2 * OP_W;
   localparam int AW     = (PW > RES_W) ? PW : RES_W;
   localparam int ONES_W = $clog2(RES_W + 1);
   localparam int IDX_W  = $clog2(RES_W + 1);

   localparam logic [15:0] ADDR_A1   = BASE_ADDR + 16'h0000;
   localparam logic [15:0] ADDR_A2   = BASE_ADDR + 16'h0008;
   localparam logic [15:0] ADDR_W    = BASE_ADDR + 16'h0010;
   localparam logic [15:0] ADDR_L    = BASE_ADDR + 16'h0018;
   localparam logic [15:0] ADDR_CTRL = BASE_ADDR + 16'h0020;

   typedef enum logic [1:0] {S_IDLE, S_MULT, S_COUNT, S_DONE} state_t;

   state_t              state_q, state_d;
   logic                srd_q, swr_q;
   logic [OP_W-1:0]     a1_q, a1_d, a2_q, a2_d;
   logic [RES_W-1:0]    w_q, w_d;
   logic [ONES_W-1:0]   l_q, l_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                valid_q, valid_d, done_q, done_d, busy_q, busy_d;
   logic [AW-1:0]       acc_q, acc_d, mcand_q, mcand_d;
   logic [OP_W-1:0]     mplier_q, mplier_d;
   logic [RES_W-1:0]    res_q, res_d;
   logic [ONES_W-1:0]   ones_q, ones_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [31:0]         sdata_out_q, sdata_out_d;
   logic [31:0]         gpio_in_s_q, gpio_in_s_d;
   logic [31:0]         rd_val;
   logic                rd_ev, wr_ev, idle, start;

   // Only the low OP_W bits of write data are stored; the rest are intentionally dropped.
   logic                unused_wdata;
   assign unused_wdata = ^sdata_in;

   assign rd_ev = srd & ~srd_q;
   assign wr_ev = swr & ~swr_q;
   assign idle  = (state_q == S_IDLE);
   assign start = wr_ev & (saddress == ADDR_CTRL) & idle;

   // Read mux: registers as they stand before any same-cycle write.
   always_comb begin
      rd_val = '0;
      case (saddress)
         ADDR_A1:   rd_val = 32'(a1_q);
         ADDR_A2:   rd_val = 32'(a2_q);
         ADDR_W:    rd_val = 32'(w_q);
         ADDR_L:    rd_val = 32'(l_q);
         ADDR_CTRL: rd_val = {29'b0, busy_q, done_q, valid_q};
         default:   rd_val = '0;
      endcase
   end

   // Next-state: FSM sequencing, multiply/popcount datapath, bus and GPIO registers.
   always_comb begin
      state_d     = state_q;
      a1_d        = a1_q;
      a2_d        = a2_q;
      w_d         = w_q;
      l_d         = l_q;
      cnt_d       = cnt_q;
      valid_d     = valid_q;
      done_d      = done_q;
      busy_d      = busy_q;
      acc_d       = acc_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      res_d       = res_q;
      ones_d      = ones_q;
      idx_d       = idx_q;
      sdata_out_d = sdata_out_q;
      gpio_in_s_d = gpio_latch ? gpio_in : gpio_in_s_q;

      if (rd_ev) sdata_out_d = rd_val;

      // Operand registers are frozen while an operation is in flight.
      if (wr_ev && idle && saddress == ADDR_A1) a1_d = sdata_in[OP_W-1:0];
      if (wr_ev && idle && saddress == ADDR_A2) a2_d = sdata_in[OP_W-1:0];

      case (state_q)
         S_IDLE: begin
            if (start) begin
               acc_d    = '0;
               mcand_d  = {{(AW-OP_W){1'b0}}, a1_q};
               mplier_d = a2_q;
               idx_d    = '0;
               busy_d   = 1'b1;
               done_d   = 1'b0;
               state_d  = S_MULT;
            end
         end
         S_MULT: begin
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            idx_d    = idx_q + 1'b1;
            if (idx_q == IDX_W'(OP_W - 1)) begin
               // Product is final after this step; hand its low RES_W bits to the popcount shifter.
               res_d   = acc_d[RES_W-1:0];
               ones_d  = '0;
               idx_d   = '0;
               state_d = S_COUNT;
            end
         end
         S_COUNT: begin
            res_d  = res_q >> 1;
            ones_d = ones_q + {{(ONES_W-1){1'b0}}, res_q[0]};
            idx_d  = idx_q + 1'b1;
            if (idx_q == IDX_W'(RES_W - 1)) state_d = S_DONE;
         end
         S_DONE: begin
            w_d     = acc_q[RES_W-1:0];
            l_d     = ones_q;
            // Shift is zero whenever the product cannot exceed RES_W bits.
            valid_d = ((acc_q >> RES_W) == '0);
            done_d  = 1'b1;
            busy_d  = 1'b0;
            cnt_d   = cnt_q + 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and strobe-history registers.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q <= S_IDLE;
         srd_q   <= 1'b0;
         swr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         srd_q   <= srd;
         swr_q   <= swr;
      end
   end

   // Datapath and architectural registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         a1_q        <= '0;
         a2_q        <= '0;
         w_q         <= '0;
         l_q         <= '0;
         cnt_q       <= '0;
         valid_q     <= 1'b1;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         acc_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         res_q       <= '0;
         ones_q      <= '0;
         idx_q       <= '0;
         sdata_out_q <= '0;
         gpio_in_s_q <= '0;
      end else begin
         a1_q        <= a1_d;
         a2_q        <= a2_d;
         w_q         <= w_d;
         l_q         <= l_d;
         cnt_q       <= cnt_d;
         valid_q     <= valid_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         acc_q       <= acc_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         res_q       <= res_d;
         ones_q      <= ones_d;
         idx_q       <= idx_d;
         sdata_out_q <= sdata_out_d;
         gpio_in_s_q <= gpio_in_s_d;
      end
   end

   assign sdata_out      = sdata_out_q;
   assign gpio_out       = 32'(cnt_q);
   assign gpio_in_s_insp = gpio_in_s_q;

endmodule

// File: tb/tb_gpio_mulcnt_seq.sv
// Bench for gpio_mulcnt_seq: directed vectors plus hand-written multi-cycle sequences.
// Counter width reduced to 4 so that wrap-around is reachable in a short run.
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same point.
module tb_gpio_mulcnt_seq;

   localparam int CNT_W = 4;
   localparam logic [15:0] A_A1   = 16'h0380;
   localparam logic [15:0] A_A2   = 16'h0388;
   localparam logic [15:0] A_W    = 16'h0390;
   localparam logic [15:0] A_L    = 16'h0398;
   localparam logic [15:0] A_CTRL = 16'h03A0;

   logic        clk = 1'b0;
   logic        n_reset;
   logic [15:0] saddress;
   logic        srd, swr;
   logic [31:0] sdata_in, sdata_out, gpio_in, gpio_out, gpio_in_s_insp;
   logic        gpio_latch;

   int checks = 0;
   int failures = 0;
   int exp_cnt = 0;

   gpio_mulcnt_seq #(.OP_W(24), .RES_W(32), .CNT_W(CNT_W), .BASE_ADDR(16'h0380)) dut (
      .clk(clk), .n_reset(n_reset), .saddress(saddress), .srd(srd), .swr(swr),
      .sdata_in(sdata_in), .sdata_out(sdata_out), .gpio_in(gpio_in),
      .gpio_latch(gpio_latch), .gpio_out(gpio_out), .gpio_in_s_insp(gpio_in_s_insp)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a1;
      logic [31:0] a2;
      logic [31:0] w;
      logic [31:0] l;
      logic [31:0] st;
   } vec_t;

   vec_t vecs [7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h expected=0x%08h", name, got, exp);
      end
   endtask

   task automatic bus_wr(input logic [15:0] addr, input logic [31:0] data);
      saddress = addr;
      sdata_in = data;
      swr = 1'b1;
      tick();
      swr = 1'b0;
      tick();
   endtask

   task automatic bus_rd(input logic [15:0] addr, output logic [31:0] data);
      saddress = addr;
      srd = 1'b1;
      tick();
      srd = 1'b0;
      tick();
      data = sdata_out;
   endtask

   // Raise swr at CTRL and count edges until gpio_out moves (bounded).
   task automatic start_op(output int n);
      logic [31:0] prev;
      prev = gpio_out;
      saddress = A_CTRL;
      swr = 1'b1;
      tick();
      swr = 1'b0;
      n = 1;
      while (gpio_out == prev && n < 200) begin
         tick();
         n++;
      end
      exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
   endtask

   initial begin
      logic [31:0] rd;
      int n;

      vecs[0] = '{32'h3,      32'h5,      32'h0000000F, 32'd4,  32'h3};
      vecs[1] = '{32'hFFFFFF, 32'hFFFFFF, 32'hFE000001, 32'd8,  32'h2};
      vecs[2] = '{32'h2,      32'h7,      32'd14,       32'd3,  32'h3};
      vecs[3] = '{32'h0,      32'h123,    32'h0,        32'd0,  32'h3};
      vecs[4] = '{32'h10000,  32'h10000,  32'h0,        32'd0,  32'h2};
      vecs[5] = '{32'hABCDEF, 32'h1,      32'h00ABCDEF, 32'd17, 32'h3};
      vecs[6] = '{32'hFFFF,   32'hFFFF,   32'hFFFE0001, 32'd16, 32'h3};

      n_reset = 1'b0; saddress = '0; srd = 0; swr = 0; sdata_in = '0;
      gpio_in = '0; gpio_latch = 0;
      tick(); tick();
      check("rst_gpio_out", gpio_out, 32'h0);
      check("rst_sdata_out", sdata_out, 32'h0);
      check("rst_gpio_in_s", gpio_in_s_insp, 32'h0);
      n_reset = 1'b1;
      tick();
      bus_rd(A_CTRL, rd); check("rst_status", rd, 32'h1);
      bus_rd(A_W, rd);    check("rst_W", rd, 32'h0);

      // Busy next cycle; A1 write and a second start mid-operation are both dropped.
      bus_wr(A_A1, 32'h3);
      bus_wr(A_A2, 32'h5);
      saddress = A_CTRL; swr = 1'b1; tick(); swr = 1'b0;
      bus_rd(A_CTRL, rd); check("busy_status", rd, 32'h5);
      bus_wr(A_A1, 32'h55);
      bus_wr(A_CTRL, 32'h0);
      n = 0;
      while (gpio_out == 32'h0 && n < 200) begin tick(); n++; end
      exp_cnt = 1;
      check("mid_gpio_out", gpio_out, 32'(exp_cnt));
      bus_rd(A_A1, rd);   check("mid_A1_kept", rd, 32'h3);
      bus_rd(A_W, rd);    check("mid_W", rd, 32'hF);
      bus_rd(A_L, rd);    check("mid_L", rd, 32'd4);
      repeat (100) tick();
      check("mid_single_count", gpio_out, 32'(exp_cnt));

      // Simultaneous read and write: read sees the old value.
      saddress = A_A1; sdata_in = 32'h9; srd = 1'b1; swr = 1'b1;
      tick(); srd = 1'b0; swr = 1'b0; tick();
      check("rw_same_cycle", sdata_out, 32'h3);
      bus_rd(A_A1, rd); check("rw_after", rd, 32'h9);

      // swr held for 5 cycles at CTRL is one operation.
      saddress = A_CTRL; swr = 1'b1;
      repeat (5) tick();
      swr = 1'b0;
      repeat (150) tick();
      exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
      check("held_swr_one_op", gpio_out, 32'(exp_cnt));

      // GPIO latch pulse.
      gpio_in = 32'hA5A5A5A5; gpio_latch = 1'b1; tick();
      gpio_latch = 1'b0; gpio_in = 32'h12345678; tick(); tick();
      check("gpio_latch_hold", gpio_in_s_insp, 32'hA5A5A5A5);

      // Table-driven operations.
      for (int i = 0; i < 7; i++) begin
         bus_wr(A_A1, vecs[i].a1);
         bus_wr(A_A2, vecs[i].a2);
         start_op(n);
         check($sformatf("v%0d_latency", i), 32'(n), 32'd58);
         check($sformatf("v%0d_gpio_out", i), gpio_out, 32'(exp_cnt));
         bus_rd(A_W, rd);    check($sformatf("v%0d_W", i), rd, vecs[i].w);
         bus_rd(A_L, rd);    check($sformatf("v%0d_L", i), rd, vecs[i].l);
         bus_rd(A_CTRL, rd); check($sformatf("v%0d_status", i), rd, vecs[i].st);
      end

      // Reset during MULT aborts everything.
      bus_wr(A_A1, 32'h123);
      bus_wr(A_A2, 32'h456);
      saddress = A_CTRL; swr = 1'b1; tick(); swr = 1'b0;
      repeat (10) tick();
      n_reset = 1'b0;
      #1;
      check("abort_gpio_out", gpio_out, 32'h0);
      check("abort_sdata_out", sdata_out, 32'h0);
      check("abort_gpio_in_s", gpio_in_s_insp, 32'h0);
      tick();
      n_reset = 1'b1;
      exp_cnt = 0;
      tick();
      bus_rd(A_CTRL, rd); check("abort_status", rd, 32'h1);
      bus_rd(A_W, rd);    check("abort_W", rd, 32'h0);
      bus_rd(A_A1, rd);   check("abort_A1", rd, 32'h0);
      bus_wr(A_A1, 32'h2);
      bus_wr(A_A2, 32'h7);
      start_op(n);
      check("fresh_latency", 32'(n), 32'd58);
      bus_rd(A_W, rd);    check("fresh_W", rd, 32'd14);
      bus_rd(A_L, rd);    check("fresh_L", rd, 32'd3);

      // Back-to-back starts until the operation counter wraps.
      for (int i = 0; i < (1 << CNT_W) - 1; i++) begin
         start_op(n);
         check($sformatf("wrap_%0d", i), gpio_out, 32'(exp_cnt));
      end
      check("wrap_zero", gpio_out, 32'h0);

      // Unmapped read after a non-zero read returns zero.
      bus_rd(A_W, rd);
      bus_rd(16'h03A8, rd); check("unmapped_read", rd, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
